// File: rtl/tile_loader.sv
// tile_loader: packs an input byte stream little-endian into SRAM words,
// writes them into the loader-side bank of a ping-pong input buffer, and
// tracks which bank holds a complete tile for the systolic-array side.
module tile_loader #(
   parameter  int ADDR_WIDTH = 8,
   parameter  int SRAM_WIDTH = 32,
   parameter  int TILE_WORDS = 256,
   localparam int BPW        = SRAM_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [7:0]            s_data,
   input  logic                  s_last,
   output logic                  input_wr_en,
   output logic [ADDR_WIDTH-1:0] input_wr_addr,
   output logic [SRAM_WIDTH-1:0] input_wr_data,
   output logic [BPW-1:0]        input_wr_mask,
   output logic                  loader_bank_sel,
   output logic                  array_bank_sel,
   output logic                  tile_ready,
   output logic [ADDR_WIDTH:0]   tile_len,
   input  logic                  array_release
);

   localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(BPW - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TILE_WORDS - 1);

   typedef enum logic [1:0] {FILL, DRAIN, WAIT} state_t;

   state_t                state;
   logic                  drain_second;   // second DRAIN cycle (N+2)
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            bank_full;
   logic [ADDR_WIDTH:0]   len_mem [2];

   logic [LANE_W-1:0]     lane;
   logic [SRAM_WIDTH-1:0] word_buf;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [ADDR_WIDTH:0]   len_pend;       // word count of the tile in DRAIN

   // Closed word staged for one cycle: the memory takes addr/data a cycle after wr_en.
   logic [SRAM_WIDTH-1:0] pend_data;
   logic [BPW-1:0]        pend_mask;
   logic [ADDR_WIDTH-1:0] pend_addr;

   logic                  accept;
   logic                  word_close;
   logic                  tile_close;
   logic                  release_ok;
   logic [SRAM_WIDTH-1:0] next_word;
   logic [BPW-1:0]        next_mask;

   assign accept     = s_valid && s_ready;
   assign word_close = accept && (s_last || lane == LAST_LANE);
   assign tile_close = word_close && (s_last || word_addr == LAST_ADDR);
   assign release_ok = array_release && bank_full[rd_ptr];

   assign loader_bank_sel = wr_ptr;
   assign array_bank_sel  = rd_ptr;
   assign tile_ready      = bank_full[rd_ptr];
   assign tile_len        = len_mem[rd_ptr];

   // Merge the incoming byte into the word under construction and build its lane mask.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      next_word = word_buf;
      next_mask = '0;
      for (int k = 0; k < BPW; k++) begin
         if (LANE_W'(k) == lane) next_word[8*k +: 8] = s_data;
         if (LANE_W'(k) <= lane) next_mask[k] = 1'b1;
      end
   end

   // Byte packing, word addressing and the two-stage write pipeline.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         lane          <= '0;
         word_buf      <= '0;
         word_addr     <= '0;
         len_pend      <= '0;
         pend_data     <= '0;
         pend_mask     <= '0;
         pend_addr     <= '0;
         input_wr_en   <= 1'b0;
         input_wr_addr <= '0;
         input_wr_data <= '0;
         input_wr_mask <= '0;
      end else begin
         input_wr_en <= word_close;
         if (input_wr_en) begin
            input_wr_addr <= pend_addr;
            input_wr_data <= pend_data;
            input_wr_mask <= pend_mask;
         end
         if (accept) begin
            if (word_close) begin
               pend_data <= next_word;
               pend_mask <= next_mask;
               pend_addr <= word_addr;
               lane      <= '0;
               word_buf  <= '0;    // unfilled lanes of the next word read as zero
               if (tile_close) begin
                  word_addr <= '0;
                  len_pend  <= {1'b0, word_addr} + 1'b1;
               end else begin
                  word_addr <= word_addr + 1'b1;
               end
            end else begin
               word_buf <= next_word;
               lane     <= lane + 1'b1;
            end
         end
      end
   end

   // Loader FSM with ping-pong bookkeeping: bank-full flags, stored lengths, pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FILL;
         drain_second <= 1'b0;
         s_ready      <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         bank_full    <= '0;
         // NOTE: the two length entries are reset because tile_len must read 0 out of reset.
         len_mem[0]   <= '0;
         len_mem[1]   <= '0;
      end else begin
         if (release_ok) begin
            bank_full[rd_ptr] <= 1'b0;
            rd_ptr            <= ~rd_ptr;
         end
         case (state)
            FILL: begin
               if (tile_close) begin
                  state        <= DRAIN;
                  drain_second <= 1'b0;
                  s_ready      <= 1'b0;
               end else begin
                  s_ready <= !bank_full[wr_ptr];
               end
            end
            DRAIN: begin
               if (!drain_second) begin
                  drain_second <= 1'b1;
               end else begin
                  // Bank selection stays put until the staged write has landed.
                  bank_full[wr_ptr] <= 1'b1;
                  len_mem[wr_ptr]   <= len_pend;
                  wr_ptr            <= ~wr_ptr;
                  if (bank_full[~wr_ptr]) begin
                     state <= WAIT;
                  end else begin
                     state   <= FILL;
                     s_ready <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (!bank_full[wr_ptr]) begin
                  state   <= FILL;
                  s_ready <= 1'b1;
               end
            end
            default: begin
               state   <= FILL;
               s_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
